// File: rtl/ring_ngen.sv
// ring_ngen: parametrised 1-of-RAILS ring source generator.
//
// Emits CHANNELS lockstep 1-of-RAILS DATA wavefronts separated by NULL
// wavefronts under the NCL completion handshake. The active rail of every
// channel rotates upward by STEP after each DATA wavefront unless hold is set.
// It also provides run/hold control, a wavefront counter and a stall watchdog.
//
// Ports
//   clk     in   1               single clock, rising edge
//   init    in   1               synchronous active-high reset
//   run     in   1               1 = generate wavefronts, 0 = park in NULL
//   hold    in   1               1 = keep the current rails at the DATA->NULL edge
//   TCOMP   in   CHANNELS        sink completion per channel (1 = DATA held)
//   C       out  CHANNELS*RAILS  channel k on C[k*RAILS +: RAILS]; 0 = NULL
//   wcount  out  CNT_W           DATA wavefronts issued since init (wraps)
//   stall   out  1               handshake wait reached TIMEOUT cycles
module ring_ngen #(
  parameter int RAILS     = 3,
  parameter int CHANNELS  = 1,
  parameter int STEP      = 1,
  parameter int INIT_RAIL = 0,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic                         clk,
  input  logic                         init,
  input  logic                         run,
  input  logic                         hold,
  input  logic [CHANNELS-1:0]          TCOMP,
  output logic [CHANNELS*RAILS-1:0]    C,
  output logic [CNT_W-1:0]             wcount,
  output logic                         stall
);

  localparam int RW = (RAILS > 1) ? $clog2(RAILS) : 1;

  // Reject illegal parameter sets at elaboration.
  if (RAILS < 2) begin : g_err_rails
    $error("ring_ngen: RAILS must be >= 2");
  end
  if (CHANNELS < 1) begin : g_err_channels
    $error("ring_ngen: CHANNELS must be >= 1");
  end
  if (STEP < 0 || STEP >= RAILS) begin : g_err_step
    $error("ring_ngen: STEP must be in 0..RAILS-1");
  end
  if (INIT_RAIL < 0 || INIT_RAIL >= RAILS) begin : g_err_init_rail
    $error("ring_ngen: INIT_RAIL must be in 0..RAILS-1");
  end
  if (CNT_W < 1) begin : g_err_cnt_w
    $error("ring_ngen: CNT_W must be >= 1");
  end
  if (TIMEOUT < 0) begin : g_err_timeout
    $error("ring_ngen: TIMEOUT must be >= 0");
  end

  typedef enum logic {
    NULL_WAIT = 1'b0,
    DATA_WAIT = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            wcount_q, wcount_d;
  logic [CHANNELS*RAILS-1:0]   c_q, c_d;
  logic                        allnull, alldata;
  logic                        go_data, go_null;

  // Completion join across channels: a mixed TCOMP vector satisfies neither.
  assign allnull = ~|TCOMP;
  assign alldata = &TCOMP;

  // Single-cycle strobes for the two state transitions.
  assign go_data = (state_q == NULL_WAIT) && allnull && run;
  assign go_null = (state_q == DATA_WAIT) && alldata;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    unique case (state_q)
      NULL_WAIT: begin
        if (allnull && run) begin
          state_d  = DATA_WAIT;
          wcount_d = wcount_q + CNT_W'(1);
        end
      end
      DATA_WAIT: begin
        if (alldata) begin
          state_d = NULL_WAIT;
        end
      end
      default: begin
        state_d = NULL_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= NULL_WAIT;
      wcount_q <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      c_q      <= c_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel rail pointer and output encoding
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [RW-1:0] RAIL_RST = RW'((INIT_RAIL + gi) % RAILS);

    logic [RW-1:0]    rail_q, rail_d;
    logic [RW:0]      rail_sum;
    logic [RW-1:0]    rail_next;
    logic [RAILS-1:0] onehot;

    // rail + STEP never exceeds 2*(RAILS-1), so one conditional subtract
    // gives an exact modulo for any RAILS, power of two or not.
    assign rail_sum  = {1'b0, rail_q} + (RW+1)'(STEP);
    assign rail_next = (rail_sum >= (RW+1)'(RAILS)) ?
                       RW'(rail_sum - (RW+1)'(RAILS)) : rail_sum[RW-1:0];

    // Rotation happens on the DATA->NULL edge so the next DATA already sees
    // the new value; hold freezes it for exactly that edge.
    assign rail_d = (go_null && !hold) ? rail_next : rail_q;

    assign onehot = RAILS'(1) << rail_q;

    // C only ever switches between all-zero and a full one-hot code.
    assign c_d[gi*RAILS +: RAILS] = go_data ? onehot :
                                    go_null ? '0     :
                                              c_q[gi*RAILS +: RAILS];

    always_ff @(posedge clk) begin
      if (init) begin
        rail_q <= RAIL_RST;
      end else begin
        rail_q <= rail_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
  if (TIMEOUT > 0) begin : g_wd
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;
    logic          wait_en;

    // A parked source (NULL with run low) is idle, not stalled.
    assign wait_en = (state_q == DATA_WAIT) || run;

    always_comb begin
      wait_d = wait_q;
      if (go_data || go_null) begin
        wait_d = '0;
      end else if (wait_en && (wait_q != TW'(TIMEOUT))) begin
        wait_d = wait_q + TW'(1);
      end
      // Counter saturates at TIMEOUT, so equality keeps stall asserted.
      stall_d = (wait_d == TW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
      if (init) begin
        wait_q  <= '0;
        stall_q <= 1'b0;
      end else begin
        wait_q  <= wait_d;
        stall_q <= stall_d;
      end
    end

    assign stall = stall_q;
  end else begin : g_no_wd
    assign stall = 1'b0;
  end

  assign C      = c_q;
  assign wcount = wcount_q;

endmodule

// File: tb/tb_ring_ngen.sv
// Testbench for ring_ngen: two instances (default 3-rail source and a
// 5-rail / 2-channel / STEP=2 source with watchdog and a narrow counter)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_ring_ngen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic        init0, run0, hold0;
  logic [0:0]  tc0;
  logic [2:0]  c0;
  logic [15:0] wc0;
  logic        st0;

  // Instance 1: RAILS=5, CHANNELS=2, STEP=2, INIT_RAIL=4, CNT_W=4, TIMEOUT=4
  logic        init1, run1, hold1;
  logic [1:0]  tc1;
  logic [9:0]  c1;
  logic [3:0]  wc1;
  logic        st1;

  ring_ngen #(.RAILS(3), .CHANNELS(1), .STEP(1), .INIT_RAIL(0), .CNT_W(16), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .init(init0), .run(run0), .hold(hold0), .TCOMP(tc0),
    .C(c0), .wcount(wc0), .stall(st0)
  );

  ring_ngen #(.RAILS(5), .CHANNELS(2), .STEP(2), .INIT_RAIL(4), .CNT_W(4), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .init(init1), .run(run1), .hold(hold1), .TCOMP(tc1),
    .C(c1), .wcount(wc1), .stall(st1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model configuration per instance
  int cf_rails[2] = '{3, 5};
  int cf_step[2]  = '{1, 2};
  int cf_chans[2] = '{1, 2};
  int cf_init[2]  = '{0, 4};
  int cf_cntw[2]  = '{16, 4};
  int cf_to[2]    = '{0, 4};

  // Model state: phase, number of rotations, DATA count, cycles waited
  bit m_valid[2];
  bit m_data[2];
  int m_rot[2];
  int m_n[2];
  int m_wait[2];

  bit mirror0, mirror1;

  // Literal sequences
  logic [2:0] seq0[8];
  int         nseq0;
  logic [15:0] wc_seen0;
  int r0_seq[8];
  int r1_seq[8];
  int nseq1;
  logic [3:0] wc_seen1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input logic in_init, input logic in_run,
                            input logic in_hold, input logic [1:0] in_tc);
    bit an, ad;
    an = 1'b1;
    ad = 1'b1;
    for (int k = 0; k < cf_chans[id]; k++) begin
      if (in_tc[k] === 1'b1) an = 1'b0;
      else ad = 1'b0;
    end
    if (in_init) begin
      m_valid[id] = 1'b1;
      m_data[id]  = 1'b0;
      m_rot[id]   = 0;
      m_n[id]     = 0;
      m_wait[id]  = 0;
    end else if (m_valid[id]) begin
      if (!m_data[id]) begin
        if (an && in_run) begin
          m_data[id] = 1'b1;
          m_n[id]++;
          m_wait[id] = 0;
        end else if (in_run) begin
          m_wait[id]++;
        end
      end else begin
        if (ad) begin
          m_data[id] = 1'b0;
          if (!in_hold) m_rot[id]++;
          m_wait[id] = 0;
        end else begin
          m_wait[id]++;
        end
      end
    end
  endtask

  function automatic logic [9:0] exp_c(input int id);
    logic [9:0] v;
    v = '0;
    if (m_data[id]) begin
      for (int k = 0; k < cf_chans[id]; k++)
        v[k*cf_rails[id] + (cf_init[id] + k + cf_step[id]*m_rot[id]) % cf_rails[id]] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_wc(input int id);
    return 16'(m_n[id] % (1 << cf_cntw[id]));
  endfunction

  function automatic logic exp_st(input int id);
    return (cf_to[id] > 0) && (m_wait[id] >= cf_to[id]);
  endfunction

  function automatic int rail_of(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: advance model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(0, init0, run0, hold0, {1'b0, tc0});
    model_step(1, init1, run1, hold1, tc1);
    @(negedge clk);
    if (m_valid[0]) begin
      check("m0.C",      32'(c0),  32'(exp_c(0)));
      check("m0.wcount", 32'(wc0), 32'(exp_wc(0)));
      check("m0.stall",  32'(st0), 32'(exp_st(0)));
    end
    if (m_valid[1]) begin
      check("m1.C",      32'(c1),  32'(exp_c(1)));
      check("m1.wcount", 32'(wc1), 32'(exp_wc(1)));
      check("m1.stall",  32'(st1), 32'(exp_st(1)));
    end
    if (mirror0) tc0[0] = |c0;
    if (mirror1) for (int k = 0; k < 2; k++) tc1[k] = |c1[k*5 +: 5];
  endtask

  // Re-init instance 0, let the sink mirror C, record the first ndata DATA codes.
  task automatic collect0(input int ndata, input int hold_at);
    logic [2:0] prev;
    int budget;
    init0 = 1'b1; run0 = 1'b1; hold0 = 1'b0; tc0 = 1'b0; mirror0 = 1'b0;
    tick(); tick();
    check("reset.C",      32'(c0),  32'h0);
    check("reset.wcount", 32'(wc0), 32'h0);
    check("reset.stall",  32'(st0), 32'h0);
    init0 = 1'b0; mirror0 = 1'b1;
    nseq0 = 0; prev = '0; budget = 0;
    while (nseq0 < ndata && budget < 200) begin
      hold0 = (hold_at != 0) && (nseq0 == hold_at);
      tick();
      budget++;
      if (c0 != 3'b000 && prev == 3'b000) begin
        seq0[nseq0] = c0;
        wc_seen0    = wc0;
        nseq0++;
      end
      prev = c0;
    end
    hold0 = 1'b0;
    if (nseq0 < ndata) check("collect0.budget", 32'(nseq0), 32'(ndata));
  endtask

  initial begin
    logic [2:0] exp_t1[4];
    logic [2:0] exp_t3[4];
    int exp_r0[6];
    int exp_r1[6];
    logic [9:0] prev1;
    int budget;

    exp_t1 = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_t3 = '{3'b001, 3'b010, 3'b010, 3'b100};
    exp_r0 = '{4, 1, 3, 0, 2, 4};
    exp_r1 = '{0, 2, 4, 1, 3, 0};

    init0 = 1'b1; run0 = 1'b1; hold0 = 1'b0; tc0 = 1'b0;
    init1 = 1'b1; run1 = 1'b1; hold1 = 1'b0; tc1 = 2'b00;
    mirror0 = 1'b0; mirror1 = 1'b0;

    // Defaults, sink mirrors C
    collect0(4, 0);
    for (int i = 0; i < 4; i++) check($sformatf("t1.data%0d", i), 32'(seq0[i]), 32'(exp_t1[i]));
    check("t1.wcount", 32'(wc_seen0), 32'd4);

    // hold on the 2nd DATA->NULL edge
    collect0(4, 2);
    for (int i = 0; i < 4; i++) check($sformatf("t3.data%0d", i), 32'(seq0[i]), 32'(exp_t3[i]));
    check("t3.wcount", 32'(wc_seen0), 32'd4);

    // run dropped while in DATA_WAIT
    init0 = 1'b1; tick();
    init0 = 1'b0; mirror0 = 1'b1; run0 = 1'b1;
    budget = 0;
    while (c0 == 3'b000 && budget < 20) begin tick(); budget++; end
    check("t4.first_data", 32'(c0), 32'(3'b001));
    run0 = 1'b0;
    tick();
    check("t4.null_issued", 32'(c0), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4.parked_C", 32'(c0), 32'h0);
      check("t4.parked_wcount", 32'(wc0), 32'd1);
    end
    run0 = 1'b1;
    tick();
    check("t4.resume_data", 32'(c0), 32'(3'b010));
    check("t4.resume_wcount", 32'(wc0), 32'd2);

    // 5 rails, STEP=2, 2 channels, INIT_RAIL=4
    init1 = 1'b1; tc1 = 2'b00; mirror1 = 1'b0;
    tick(); tick();
    check("t2.reset_C", 32'(c1), 32'h0);
    init1 = 1'b0; mirror1 = 1'b1;
    nseq1 = 0; prev1 = '0; budget = 0;
    while (nseq1 < 6 && budget < 200) begin
      tick();
      budget++;
      if (c1 != 10'h0 && prev1 == 10'h0) begin
        r0_seq[nseq1] = rail_of(c1[4:0]);
        r1_seq[nseq1] = rail_of(c1[9:5]);
        wc_seen1 = wc1;
        nseq1++;
      end
      prev1 = c1;
    end
    if (nseq1 < 6) check("t2.budget", 32'(nseq1), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2.ch0_rail%0d", i), 32'(r0_seq[i]), 32'(exp_r0[i]));
      check($sformatf("t2.ch1_rail%0d", i), 32'(r1_seq[i]), 32'(exp_r1[i]));
    end
    check("t2.wcount", 32'(wc_seen1), 32'd6);

    // Mixed completion keeps DATA
    mirror1 = 1'b0;
    init1 = 1'b1; tc1 = 2'b00; tick();
    init1 = 1'b0; tick();
    check("t5.first_data", 32'(c1), 32'h030);
    tc1 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5.mixed_hold", 32'(c1), 32'h030);
    end
    tc1 = 2'b11;
    tick();
    check("t5.null", 32'(c1), 32'h0);

    // Watchdog with TCOMP stuck low in DATA_WAIT
    tc1 = 2'b00;
    tick();
    check("t6.data", 32'(c1), 32'h082);
    for (int j = 2; j <= 7; j++) begin
      tick();
      if (j <= 3) check("t6.no_stall", 32'(st1), 32'h0);
      else if (j >= 6) check("t6.stall", 32'(st1), 32'h1);
    end
    tc1 = 2'b11;
    tick();
    check("t6.stall_clear", 32'(st1), 32'h0);
    check("t6.null", 32'(c1), 32'h0);
    tc1 = 2'b00;
    tick();
    check("t6.data2", 32'(c1), 32'h208);
    init1 = 1'b1;
    tick();
    check("t6.init_C", 32'(c1), 32'h0);
    check("t6.init_wcount", 32'(wc1), 32'h0);
    check("t6.init_stall", 32'(st1), 32'h0);
    init1 = 1'b0;
    tick();
    check("t6.init_rail_data", 32'(c1), 32'h030);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      init0 = ($urandom_range(0, 199) == 0);
      run0  = ($urandom_range(0, 9) != 0);
      hold0 = ($urandom_range(0, 3) == 0);
      tc0[0] = ($urandom_range(0, 3) != 0) ? |c0 : 1'($urandom_range(0, 1));
      init1 = ($urandom_range(0, 199) == 0);
      run1  = ($urandom_range(0, 9) != 0);
      hold1 = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 2; k++)
        tc1[k] = ($urandom_range(0, 4) != 0) ? |c1[k*5 +: 5] : 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
